// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE CPU sequencer: run states, phase indices, LED patterns.
package simple_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } seq_state_e;

    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;

    localparam logic [7:0] LED_RUN  = 8'hFF;
    localparam logic [7:0] LED_HALT = 8'h81;
    localparam logic [7:0] LED_IDLE = 8'h00;

    function automatic logic [4:0] phase_onehot(input logic [2:0] p);
        phase_onehot = 5'b00001 << p;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive memory-stall cycles; expired marks STALL_MAX stalls already taken.
module stall_watchdog
    import simple_pkg::*;
#(
    parameter int unsigned STALL_MAX = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int unsigned W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(STALL_MAX));

    // Saturates at STALL_MAX so a late clear cannot see a wrapped value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction scheduler with run/step/halt control and a completed-instruction counter.
// Optional stall timeout enabled by defining PHASE_SEQ_STALL_TIMEOUT_EN.
module phase_sequencer
    import simple_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned STALL_MAX = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_in,
    input  logic             mem_busy,
    output logic [4:0]       phase_en,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [7:0]       status_led
);

    seq_state_e       state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic             stop_pend_q, stop_pend_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       phase_en_q, phase_en_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic [7:0]       led_q, led_d;
    logic             stall_expired;
    logic             executing;
    logic             halt_seen;
    logic             stop_seen;

    assign executing = (state_q == RUN) || (state_q == STEP);

`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
    logic fault_q, fault_d;
    logic stall_count_en;

    assign stall_count_en = executing && (phase_q == P3) && mem_busy;

    stall_watchdog #(
        .STALL_MAX(STALL_MAX)
    ) u_stall_watchdog (
        .clock   (clock),
        .reset   (reset),
        .count_en(stall_count_en),
        .clear   (!stall_count_en),
        .expired (stall_expired)
    );

    assign fault = fault_q;
`else
    assign stall_expired = 1'b0;
    assign fault         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        stop_pend_d = stop_pend_q;
        halt_pend_d = halt_pend_q;
        count_d     = count_q;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
        fault_d     = fault_q;
`endif
        // Current-cycle requests count toward the instruction in flight, including in P4.
        halt_seen = halt_pend_q || halt_in;
        stop_seen = stop_pend_q || ((state_q == RUN) && run_req);

        case (state_q)
            IDLE: begin
                phase_d = P0;
                if (run_req) begin
                    state_d = RUN;
                end else if (step_req) begin
                    state_d = STEP;
                end
            end
            RUN, STEP: begin
                halt_pend_d = halt_seen;
                stop_pend_d = stop_seen;
                if (phase_q == P3) begin
                    if (!mem_busy) begin
                        phase_d = P4;
                    end else if (stall_expired) begin
                        state_d     = HALTED;
                        phase_d     = P0;
                        halt_pend_d = 1'b0;
                        stop_pend_d = 1'b0;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
                        fault_d     = 1'b1;
`endif
                    end
                end else if (phase_q == P4) begin
                    count_d     = count_q + 1'b1;
                    phase_d     = P0;
                    halt_pend_d = 1'b0;
                    stop_pend_d = 1'b0;
                    if (halt_seen) begin
                        state_d = HALTED;
                    end else if ((state_q == STEP) || stop_seen) begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                phase_d = P0;
            end
        endcase

        // Outputs are registered from the next-state values so they align with the phase.
        running_d  = (state_d == RUN) || (state_d == STEP);
        halted_d   = (state_d == HALTED);
        phase_en_d = running_d ? phase_onehot(phase_d) : 5'b00000;
        if (running_d) begin
            led_d = LED_RUN;
        end else if (halted_d) begin
            led_d = LED_HALT;
        end else begin
            led_d = LED_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= P0;
            stop_pend_q <= 1'b0;
            halt_pend_q <= 1'b0;
            count_q     <= '0;
            phase_en_q  <= '0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            led_q       <= LED_IDLE;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            halt_pend_q <= halt_pend_d;
            count_q     <= count_d;
            phase_en_q  <= phase_en_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            led_q       <= led_d;
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign phase_en    = phase_en_q;
    assign phase       = phase_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign instr_count = count_q;
    assign status_led  = led_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_phase_sequencer;

    localparam int CNT_W     = 4;
    localparam int STALL_MAX = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             run_req, step_req, halt_in, mem_busy;
    logic [4:0]       phase_en;
    logic [2:0]       phase;
    logic             running, halted, fault;
    logic [CNT_W-1:0] instr_count;
    logic [7:0]       status_led;

    phase_sequencer #(
        .CNT_W    (CNT_W),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_in    (halt_in),
        .mem_busy   (mem_busy),
        .phase_en   (phase_en),
        .phase      (phase),
        .running    (running),
        .halted     (halted),
        .fault      (fault),
        .instr_count(instr_count),
        .status_led (status_led)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pe;
        int ph;
        int run;
        int hlt;
        int flt;
        int cnt;
        int led;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode 0 idle, 1 continuous run, 2 single step, 3 halted.
    int m_mode  = 0;
    int m_ph    = 0;
    int m_stop  = 0;
    int m_halt  = 0;
    int m_cnt   = 0;
    int m_stall = 0;
    int m_fault = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit rst, input bit run, input bit step,
                                       input bit hlt, input bit busy);
        exp_t e;
        if (rst) begin
            m_mode = 0; m_ph = 0; m_stop = 0; m_halt = 0;
            m_cnt = 0; m_stall = 0; m_fault = 0;
        end else if (m_mode == 0) begin
            if (run) m_mode = 1;
            else if (step) m_mode = 2;
            m_ph = 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (hlt) m_halt = 1;
            if (run && m_mode == 1) m_stop = 1;
            if (m_ph == 3 && busy) begin
`ifdef PHASE_SEQ_STALL_TIMEOUT_EN
                if (m_stall >= STALL_MAX) begin
                    m_mode = 3; m_ph = 0; m_fault = 1;
                    m_stop = 0; m_halt = 0; m_stall = 0;
                end else begin
                    m_stall++;
                end
`endif
            end else if (m_ph == 4) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_ph = 0;
                if (m_halt != 0) m_mode = 3;
                else if (m_mode == 2 || m_stop != 0) m_mode = 0;
                m_stop = 0; m_halt = 0; m_stall = 0;
            end else begin
                m_ph++;
                m_stall = 0;
            end
        end
        e.run = (m_mode == 1 || m_mode == 2) ? 1 : 0;
        e.hlt = (m_mode == 3) ? 1 : 0;
        e.pe  = e.run ? (1 << m_ph) : 0;
        e.ph  = m_ph;
        e.flt = m_fault;
        e.cnt = m_cnt;
        e.led = e.run ? 8'hFF : (e.hlt ? 8'h81 : 8'h00);
        exp_q.push_back(e);
    endfunction

    task automatic drive(input bit rst, input bit run, input bit step,
                         input bit hlt, input bit busy);
        reset    = rst;
        run_req  = run;
        step_req = step;
        halt_in  = hlt;
        mem_busy = busy;
        model_step(rst, run, step, hlt, busy);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("phase_en", int'(phase_en), e.pe);
            check("phase", int'(phase), e.ph);
            check("running", int'(running), e.run);
            check("halted", int'(halted), e.hlt);
            check("fault", int'(fault), e.flt);
            check("instr_count", int'(instr_count), e.cnt);
            check("status_led", int'(status_led), e.led);
        end
    end

    initial begin
        int halted_for;
        // Reset, then a single step with no stalls.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(8);

        // Continuous run, stop requested during P2 of the third instruction.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Memory busy for four cycles from P3 entry, then stop.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);

        // Halt pulsed in P1 of the second instruction; later requests must be ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous run and step, then reset during P2.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Single step with halt sampled in P4 itself.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Memory held busy: waits forever, or faults when the timeout is built in.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long run to wrap the narrow instruction counter.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5 * 18);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);

        // Randomized traffic; reset releases the sequencer when it sits halted.
        halted_for = 0;
        for (int i = 0; i < 800; i++) begin
            bit r_rst, r_run, r_step, r_hlt, r_busy;
            halted_for = (m_mode == 3) ? halted_for + 1 : 0;
            r_rst  = (halted_for > 4) || ($urandom_range(0, 299) == 0);
            r_run  = ($urandom_range(0, 9) == 0);
            r_step = ($urandom_range(0, 7) == 0);
            r_hlt  = ($urandom_range(0, 59) == 0);
            r_busy = ($urandom_range(0, 2) == 0);
            drive(r_rst, r_run, r_step, r_hlt, r_busy);
        end
        idle(3);

        @(negedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
